// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory access path.
// The 13-bit address space holds ROM at 0000h..17FFh and RAM at 1800h..1FFFh.
// The data path is 8 bits wide.
package cpu_mem_pkg;

    localparam int MEM_AW = 13;
    localparam int MEM_DW = 8;
    localparam int WAIT_W = 3;

    localparam logic [MEM_AW-1:0] RAM_BASE = 13'h1800;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    // RAM occupies the top quarter of the map, so the two top address bits are enough.
    function automatic logic is_ram_region(input logic [MEM_AW-1:0] addr);
        is_ram_region = (addr[MEM_AW-1:MEM_AW-2] == RAM_BASE[MEM_AW-1:MEM_AW-2]);
    endfunction

    // Wait count loaded at accept time for the addressed region.
    function automatic logic [WAIT_W-1:0] region_wait(
        input logic              is_ram,
        input logic [WAIT_W-1:0] rom_wait,
        input logic [WAIT_W-1:0] ram_wait
    );
        if (is_ram) begin
            region_wait = ram_wait;
        end else begin
            region_wait = rom_wait;
        end
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: loadable down-counter that paces the strobe phase of a memory access.
// Load has priority over decrement.
// The count stops at zero, so a stray decrement can never wrap into a long wait.
module mem_wait_ctr
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              dec,
    output logic [WAIT_W-1:0] value,
    output logic              zero
);

    logic [WAIT_W-1:0] cnt_r;

    // Count register: reset, load, saturating decrement, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {WAIT_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {WAIT_W{1'b0}})) begin
            cnt_r <= cnt_r - {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign value = cnt_r;
    assign zero  = (cnt_r == {WAIT_W{1'b0}});

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one CPU memory transaction at a time onto the ROM/RAM arrays.
// The request is latched on accept and held for the whole transaction.
// The external decoder's rom_sel/ram_sel gate the strobes.
// After the region's wait states, read data is captured and a single-cycle response is returned.
// Optional feature macro: MEM_ACCESS_ERR_EN.
//   When defined, rsp_err flags writes to ROM and accesses that no region decodes.
//   When undefined, rsp_err stays 0.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [MEM_AW-1:0] req_addr,
    input  logic [MEM_DW-1:0] req_wdata,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              rom_sel,
    input  logic              ram_sel,
    output logic              rom_rd,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [MEM_DW-1:0] ram_wdata,
    input  logic [MEM_DW-1:0] rom_rdata,
    input  logic [MEM_DW-1:0] ram_rdata,
    output logic              rsp_valid,
    output logic [MEM_DW-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [WAIT_W-1:0] ROM_WAIT_C = WAIT_W'(ROM_WAIT);
    localparam logic [WAIT_W-1:0] RAM_WAIT_C = WAIT_W'(RAM_WAIT);

    state_e            state_r;
    state_e            state_next_s;

    logic [MEM_AW-1:0] addr_r;
    logic [MEM_DW-1:0] wdata_r;
    logic              we_r;
    logic [MEM_DW-1:0] rdata_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic              ready_r;

    logic              accept_s;
    logic              done_s;
    logic              in_access_s;
    logic              dec_s;
    logic [WAIT_W-1:0] load_val_s;
    logic [WAIT_W-1:0] wait_val_s;
    logic              wait_zero_s;
    logic [MEM_DW-1:0] rd_mux_s;
    logic              err_s;
    logic              rom_rd_s;
    logic              ram_rd_s;
    logic              ram_wr_s;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------

    // State register.
    // Reset returns to IDLE from anywhere, which also aborts an access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the accept/complete events that drive the data path.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (wait_zero_s) begin
                    done_s       = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign in_access_s = (state_r == ACCESS);

    // ------------------------------------------------------------------
    // Wait-state counter
    // ------------------------------------------------------------------

    // Region is decided from the raw request address.
    // The counter is therefore loaded on the accept edge, without waiting for the decoder.
    assign load_val_s = region_wait(is_ram_region(req_addr), ROM_WAIT_C, RAM_WAIT_C);
    assign dec_s      = in_access_s && (wait_val_s != {WAIT_W{1'b0}});

    mem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .value    (wait_val_s),
        .zero     (wait_zero_s)
    );

    // ------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------

    // Address, direction and write data are sampled only on accept.
    // Later changes on the request bus therefore cannot disturb a transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {MEM_AW{1'b0}};
            wdata_r <= {MEM_DW{1'b0}};
            we_r    <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            we_r    <= req_we;
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    // ------------------------------------------------------------------
    // Strobes and read data selection
    // ------------------------------------------------------------------

    // Strobes follow the decoder selects during ACCESS.
    // A write to ROM, or an address no region claims, therefore produces no strobe at all.
    always_comb begin
        rom_rd_s = 1'b0;
        ram_rd_s = 1'b0;
        ram_wr_s = 1'b0;
        if (in_access_s) begin
            rom_rd_s = rom_sel & ~we_r;
            ram_rd_s = ram_sel & ~we_r;
            ram_wr_s = ram_sel &  we_r;
        end else begin
            rom_rd_s = 1'b0;
            ram_rd_s = 1'b0;
            ram_wr_s = 1'b0;
        end
    end

    // Read return mux: ROM wins if both selects were ever high; undecoded reads return zero.
    always_comb begin
        rd_mux_s = {MEM_DW{1'b0}};
        if (rom_sel) begin
            rd_mux_s = rom_rdata;
        end else if (ram_sel) begin
            rd_mux_s = ram_rdata;
        end else begin
            rd_mux_s = {MEM_DW{1'b0}};
        end
    end

`ifdef MEM_ACCESS_ERR_EN
    // Error condition evaluated on the completing ACCESS cycle.
    always_comb begin
        err_s = (we_r & rom_sel) | (~rom_sel & ~ram_sel);
    end
`else
    assign err_s = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------

    // Response registers.
    // rsp_valid is set on the edge that enters RESP, so it lasts exactly one cycle.
    // Writes leave rsp_rdata untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rdata_r     <= {MEM_DW{1'b0}};
        end else begin
            rsp_valid_r <= done_s;
            rsp_err_r   <= done_s & err_s;
            if (done_s && !we_r) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Ready register: high exactly when the sequencer sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r <= 1'b1;
        end else begin
            ready_r <= (state_next_s == IDLE);
        end
    end

    assign req_ready = ready_r;
    assign mem_addr  = addr_r;
    assign ram_wdata = wdata_r;
    assign rom_rd    = rom_rd_s;
    assign ram_rd    = ram_rd_s;
    assign ram_wr    = ram_wr_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl.
// The environment provides an address decoder, a ROM with a fixed content function and a RAM written by the DUT strobes.
// Directed vectors come from a table of constant expectations.
// Random transactions are checked against a transaction-level model.
// A hand-written sequence covers reset in the middle of an access.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int TB_ROM_WAIT = 1;
    localparam int TB_RAM_WAIT = 0;
`ifdef MEM_ACCESS_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [12:0] req_addr;
    logic [7:0]  req_wdata;
    logic [12:0] mem_addr;
    logic        rom_sel;
    logic        ram_sel;
    logic        rom_rd;
    logic        ram_rd;
    logic        ram_wr;
    logic [7:0]  ram_wdata;
    logic [7:0]  rom_rdata;
    logic [7:0]  ram_rdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    logic        kill;
    bit   [7:0]  env_ram     [8192];
    bit          env_written [8192];
    logic [7:0]  ref_ram     [int];
    logic [7:0]  exp_prev;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .ROM_WAIT (TB_ROM_WAIT),
        .RAM_WAIT (TB_RAM_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_addr  (mem_addr),
        .rom_sel   (rom_sel),
        .ram_sel   (ram_sel),
        .rom_rd    (rom_rd),
        .ram_rd    (ram_rd),
        .ram_wr    (ram_wr),
        .ram_wdata (ram_wdata),
        .rom_rdata (rom_rdata),
        .ram_rdata (ram_rdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    function automatic logic [7:0] rom_init(input logic [12:0] a);
        if (a == 13'h0005) return 8'hA5;
        return a[7:0] ^ {3'b000, a[12:8]};
    endfunction

    function automatic logic [7:0] ram_init(input logic [12:0] a);
        return a[7:0] + 8'h11;
    endfunction

    // Environment: decoder (with an override that kills both selects), ROM and RAM.
    assign rom_sel   = !kill && (mem_addr <  13'h1800);
    assign ram_sel   = !kill && (mem_addr >= 13'h1800);
    assign rom_rdata = rom_init(mem_addr);
    assign ram_rdata = env_written[mem_addr] ? env_ram[mem_addr] : ram_init(mem_addr);

    always @(posedge clk) begin
        if (ram_wr) begin
            env_ram[mem_addr]     <= ram_wdata;
            env_written[mem_addr] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run one transaction and compare every observable against the given expectations.
    // kind: 0 none, 1 rom_rd, 2 ram_rd, 3 ram_wr.
    task automatic run_txn(input string tag, input logic we, input logic [12:0] addr,
                           input logic [7:0] wdata, input logic kill_sel,
                           input int kind, input int cnt, input int rsp,
                           input logic [7:0] rdata, input logic err);
        int          hit_cnt;
        int          first_c;
        int          last_c;
        int          other;
        int          rsp_c;
        int          ready_hi;
        int          guard;
        logic [7:0]  got_rdata;
        logic        got_err;
        logic [12:0] got_addr;
        logic [2:0]  strb;
        hit_cnt = 0; first_c = 0; last_c = 0; other = 0; rsp_c = 0; ready_hi = 0; guard = 0;
        got_rdata = 8'h00; got_err = 1'b0; got_addr = 13'h0000;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("%s.ready_before", tag), 32'(req_ready), 32'd1);
        kill      = kill_sel;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) got_addr = mem_addr;
            if (req_ready) ready_hi++;
            strb = {ram_wr, ram_rd, rom_rd};
            for (int k = 1; k <= 3; k++) begin
                if (strb[k-1]) begin
                    if (k == kind) begin
                        hit_cnt++;
                        if (first_c == 0) first_c = c;
                        last_c = c;
                    end else begin
                        other++;
                    end
                end
            end
            if (rsp_valid) begin
                rsp_c     = c;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
                break;
            end
        end
        chk($sformatf("%s.mem_addr", tag), 32'(got_addr), 32'(addr));
        chk($sformatf("%s.strobe_cycles", tag), 32'(hit_cnt), 32'(cnt));
        if (cnt > 0) begin
            chk($sformatf("%s.strobe_first", tag), 32'(first_c), 32'd1);
            chk($sformatf("%s.strobe_last", tag), 32'(last_c), 32'(cnt));
        end
        chk($sformatf("%s.wrong_strobes", tag), 32'(other), 32'd0);
        chk($sformatf("%s.rsp_cycle", tag), 32'(rsp_c), 32'(rsp));
        chk($sformatf("%s.ready_busy", tag), 32'(ready_hi), 32'd0);
        chk($sformatf("%s.rsp_rdata", tag), 32'(got_rdata), 32'(rdata));
        chk($sformatf("%s.rsp_err", tag), 32'(got_err), 32'(err));
        if (we) chk($sformatf("%s.ram_wdata", tag), 32'(ram_wdata), 32'(wdata));
        @(negedge clk);
        chk($sformatf("%s.rsp_pulse", tag), 32'(rsp_valid), 32'd0);
        chk($sformatf("%s.ready_after", tag), 32'(req_ready), 32'd1);
        kill = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        kill;
        int          kind;
        int          cnt;
        int          rsp;
        logic [7:0]  rdata;
        logic        err;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        ks;
        logic        is_ram;
        int          w;
        int          kind;
        logic [7:0]  rd;
        logic        err;
        int          rsp_seen;
        int          rsp_at;
        int          rom_hits;
        logic [7:0]  rsp_val;

        // Directed vectors, expectations written for ROM_WAIT=1, RAM_WAIT=0.
        vecs[0] = '{1'b0, 13'h0005, 8'h00, 1'b0, 1, 2, 3, 8'hA5, 1'b0};
        vecs[1] = '{1'b1, 13'h1800, 8'h3C, 1'b0, 3, 1, 2, 8'hA5, 1'b0};
        vecs[2] = '{1'b0, 13'h1FFF, 8'h00, 1'b0, 2, 1, 2, 8'h10, 1'b0};
        vecs[3] = '{1'b0, 13'h17FF, 8'h00, 1'b0, 1, 2, 3, 8'hE8, 1'b0};
        vecs[4] = '{1'b0, 13'h1800, 8'h00, 1'b0, 2, 1, 2, 8'h3C, 1'b0};
        vecs[5] = '{1'b1, 13'h0100, 8'h77, 1'b0, 0, 0, 3, 8'h3C, ERR_ON};
        vecs[6] = '{1'b0, 13'h0200, 8'h00, 1'b1, 0, 0, 3, 8'h00, ERR_ON};

        kill = 1'b0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 13'h1ABC; req_wdata = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.mem_addr", 32'(mem_addr), 32'd0);
        chk("reset.ram_wdata", 32'(ram_wdata), 32'd0);
        chk("reset.rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("reset.strobes", 32'({rom_rd, ram_rd, ram_wr}), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_err", 32'(rsp_err), 32'd0);
        chk("reset.req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].kill,
                    vecs[i].kind, vecs[i].cnt, vecs[i].rsp, vecs[i].rdata, vecs[i].err);
            if (vecs[i].we && vecs[i].addr >= 13'h1800 && !vecs[i].kill)
                ref_ram[int'(vecs[i].addr)] = vecs[i].wdata;
            exp_prev = vecs[i].rdata;
        end

        // Random transactions against the transaction-level model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       addr = 13'($urandom_range(0, 8191));
                1:       addr = 13'(13'h17F0 + $urandom_range(0, 31));
                2:       addr = 13'(13'h1800 + $urandom_range(0, 15));
                default: addr = 13'($urandom_range(0, 15));
            endcase
            we     = 1'($urandom_range(0, 1));
            wdata  = 8'($urandom_range(0, 255));
            ks     = ($urandom_range(0, 9) == 0);
            is_ram = (addr >= 13'h1800);
            w      = is_ram ? TB_RAM_WAIT : TB_ROM_WAIT;
            if (ks)          kind = 0;
            else if (!is_ram) kind = we ? 0 : 1;
            else              kind = we ? 3 : 2;
            if (we)           rd = exp_prev;
            else if (ks)      rd = 8'h00;
            else if (!is_ram) rd = rom_init(addr);
            else              rd = ref_ram.exists(int'(addr)) ? ref_ram[int'(addr)] : ram_init(addr);
            err = ERR_ON && (ks || (we && !is_ram));
            run_txn($sformatf("rnd%0d", i), we, addr, wdata, ks, kind,
                    (kind == 0) ? 0 : w + 1, w + 2, rd, err);
            if (we && is_ram && !ks) ref_ram[int'(addr)] = wdata;
            exp_prev = rd;
        end

        // Reset in cycle 1 of a ROM read with the request held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 13'h0005; req_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk("rst.c1_rom_rd", 32'(rom_rd), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.c2_strobes", 32'({rom_rd, ram_rd, ram_wr}), 32'd0);
        chk("rst.c2_ready", 32'(req_ready), 32'd1);
        chk("rst.c2_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.c2_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_seen = 0; rsp_at = 0; rom_hits = 0; rsp_val = 8'h00;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            if (rom_rd) rom_hits++;
            if (rsp_valid) begin
                rsp_seen++;
                rsp_at  = c;
                rsp_val = rsp_rdata;
            end
        end
        chk("rst.reaccept_rom_rd", 32'(rom_hits), 32'd2);
        chk("rst.rsp_count", 32'(rsp_seen), 32'd1);
        chk("rst.rsp_cycle", 32'(rsp_at), 32'd5);
        chk("rst.rsp_rdata", 32'(rsp_val), 32'hA5);
        chk("rst.ready_end", 32'(req_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
